// File: rtl/dual_port_mem_responder_pkg.sv
// Shared bus definitions for the dual-port memory responder:
// command encodings, the response record carried through the delay lines,
// and the byte-address to word-index mapping.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam resp_t RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: 32'h0000_0000};

    // Word index of a byte address; the mask wraps it into the array.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int depth_words);
        return (addr >> 2) & 32'(depth_words - 1);
    endfunction

endpackage

// File: rtl/dual_port_mem_responder_if.sv
// Instruction/data bus bundle between the pipeline (master) and the
// memory responder (slave). Both ports respond with a fixed latency and
// have no backpressure.
interface dual_port_mem_responder_if;

    logic [1:0]  i_cmd;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_err;

    logic [1:0]  d_cmd;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_err;

    modport master (
        output i_cmd, i_addr,
        input  i_rdata, i_rvalid, i_err,
        output d_cmd, d_addr, d_wdata,
        input  d_rdata, d_rvalid, d_err
    );

    modport slave (
        input  i_cmd, i_addr,
        output i_rdata, i_rvalid, i_err,
        input  d_cmd, d_addr, d_wdata,
        output d_rdata, d_rvalid, d_err
    );

endinterface

// File: rtl/dual_port_mem_responder_pipe.sv
// mem_resp_pipe: LATENCY-deep delay line of response records.
// The last stage drives the port outputs directly, so they are registered.
// Reset clears every stage, which drops all in-flight responses.
module mem_resp_pipe
    import mem_bus_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t head,
    output resp_t tail
);

    resp_t stage_r [LATENCY];

    // Shift the response record one stage per cycle; reset empties the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= RESP_IDLE;
            end
        end else begin
            stage_r[0] <= head;
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tail = stage_r[LATENCY-1];

endmodule

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: shared word array serving a read-only I-port and
// a load/store D-port, each response returned after LATENCY cycles.
// Optional build macro: MEM_ERR_CHECK_EN enables misalignment/range errors;
// without it addresses wrap and err outputs stay 0.
module dual_port_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    dual_port_mem_responder_if.slave   bus,
    output logic [31:0]                load_count,
    output logic [31:0]                store_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MEM_ERR_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
`endif

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [31:0]   load_count_r;
    logic [31:0]   store_count_r;

    logic [AW-1:0] i_idx_s;
    logic [AW-1:0] d_idx_s;
    logic          i_err_s;
    logic          d_err_s;
    logic          i_load_s;
    logic          d_load_s;
    logic          d_store_s;
    logic [1:0]    load_inc_s;
    logic [32:0]   load_sum_s;
    logic [31:0]   load_next_s;
    logic [31:0]   store_next_s;
    resp_t         i_head_s;
    resp_t         d_head_s;
    resp_t         i_tail_s;
    resp_t         d_tail_s;

    assign i_idx_s = AW'(word_index(bus.i_addr, DEPTH_WORDS));
    assign d_idx_s = AW'(word_index(bus.d_addr, DEPTH_WORDS));

    // Address checks: only the error-checking build flags misaligned or out-of-range accesses.
    always_comb begin
`ifdef MEM_ERR_CHECK_EN
        i_err_s = (bus.i_addr[1:0] != 2'b00) || (bus.i_addr >= ADDR_LIMIT);
        d_err_s = (bus.d_addr[1:0] != 2'b00) || (bus.d_addr >= ADDR_LIMIT);
`else
        i_err_s = 1'b0;
        d_err_s = 1'b0;
`endif
    end

    // Command decode; the reserved code and anything but LOAD on the I-port are idle.
    always_comb begin
        i_load_s  = (bus.i_cmd == BUS_LOAD);
        d_load_s  = (bus.d_cmd == BUS_LOAD);
        d_store_s = (bus.d_cmd == BUS_STORE);
    end

    // Build the responses entering the delay lines; reads see the array before this edge's store.
    always_comb begin
        i_head_s = RESP_IDLE;
        d_head_s = RESP_IDLE;
        if (i_load_s) begin
            i_head_s.valid = 1'b1;
            i_head_s.err   = i_err_s;
            i_head_s.data  = i_err_s ? 32'h0000_0000 : mem_r[i_idx_s];
        end else begin
            i_head_s = RESP_IDLE;
        end
        if (d_load_s) begin
            d_head_s.valid = 1'b1;
            d_head_s.err   = d_err_s;
            d_head_s.data  = d_err_s ? 32'h0000_0000 : mem_r[d_idx_s];
        end else if (d_store_s) begin
            d_head_s.valid = 1'b1;
            d_head_s.err   = d_err_s;
            d_head_s.data  = 32'h0000_0000;
        end else begin
            d_head_s = RESP_IDLE;
        end
    end

    // Array write port: error-free stores land at the sampling edge; nothing is written in reset.
    always_ff @(posedge clk) begin
        if (!rst && d_store_s && !d_err_s) begin
            mem_r[d_idx_s] <= bus.d_wdata;
        end
    end

    // Next counter values, saturating at all-ones.
    always_comb begin
        load_inc_s = {1'b0, (i_load_s && !i_err_s)} + {1'b0, (d_load_s && !d_err_s)};
        load_sum_s = {1'b0, load_count_r} + {31'h0, load_inc_s};
        if (load_sum_s[32]) begin
            load_next_s = 32'hFFFF_FFFF;
        end else begin
            load_next_s = load_sum_s[31:0];
        end
        if (d_store_s && !d_err_s && (store_count_r != 32'hFFFF_FFFF)) begin
            store_next_s = store_count_r + 32'h0000_0001;
        end else begin
            store_next_s = store_count_r;
        end
    end

    // Accepted-command counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count_r  <= 32'h0000_0000;
            store_count_r <= 32'h0000_0000;
        end else begin
            load_count_r  <= load_next_s;
            store_count_r <= store_next_s;
        end
    end

    mem_resp_pipe #(.LATENCY(LATENCY)) u_i_pipe (
        .clk  (clk),
        .rst  (rst),
        .head (i_head_s),
        .tail (i_tail_s)
    );

    mem_resp_pipe #(.LATENCY(LATENCY)) u_d_pipe (
        .clk  (clk),
        .rst  (rst),
        .head (d_head_s),
        .tail (d_tail_s)
    );

    assign bus.i_rvalid = i_tail_s.valid;
    assign bus.i_err    = i_tail_s.err;
    assign bus.i_rdata  = i_tail_s.data;
    assign bus.d_rvalid = d_tail_s.valid;
    assign bus.d_err    = d_tail_s.err;
    assign bus.d_rdata  = d_tail_s.data;
    assign load_count   = load_count_r;
    assign store_count  = store_count_r;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Bench for dual_port_mem_responder: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_dual_port_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;
    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_STORE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] load_count;
    logic [31:0] store_count;

    always #5 clk = ~clk;

    dual_port_mem_responder_if bus ();

    dual_port_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .load_count  (load_count),
        .store_count (store_count)
    );

    typedef struct {
        bit          valid;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_i[$];
    exp_t        exp_d[$];
    logic [31:0] model_mem [DEPTH];
    longint      model_loads;
    longint      model_stores;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr);
`ifdef MEM_ERR_CHECK_EN
        return (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
        return (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic longint sat(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
    endfunction

    task automatic refill();
        exp_t idle;
        idle.valid = 1'b0; idle.err = 1'b0; idle.data = 32'h0;
        exp_i.delete();
        exp_d.delete();
        for (int k = 0; k < LAT; k++) begin
            exp_i.push_back(idle);
            exp_d.push_back(idle);
        end
        model_loads  = 0;
        model_stores = 0;
    endtask

    // One cycle at the falling edge: check what is due now, then present a new command.
    task automatic step(input logic [1:0] icmd, input logic [31:0] iaddr,
                        input logic [1:0] dcmd, input logic [31:0] daddr, input logic [31:0] wdata);
        exp_t ei, ed, ni, nd;
        check("queue_depth", 32'(exp_i.size() + exp_d.size()), 32'(2 * LAT));
        ei = exp_i.pop_front();
        ed = exp_d.pop_front();
        check("i_rvalid", {31'h0, bus.i_rvalid}, {31'h0, ei.valid});
        check("i_err",    {31'h0, bus.i_err},    {31'h0, ei.err});
        check("i_rdata",  bus.i_rdata,           ei.data);
        check("d_rvalid", {31'h0, bus.d_rvalid}, {31'h0, ed.valid});
        check("d_err",    {31'h0, bus.d_err},    {31'h0, ed.err});
        check("d_rdata",  bus.d_rdata,           ed.data);
        check("load_count",  load_count,  model_loads[31:0]);
        check("store_count", store_count, model_stores[31:0]);

        bus.i_cmd = icmd; bus.i_addr = iaddr;
        bus.d_cmd = dcmd; bus.d_addr = daddr; bus.d_wdata = wdata;

        ni.valid = 1'b0; ni.err = 1'b0; ni.data = 32'h0;
        nd = ni;
        if (icmd == C_LOAD) begin
            ni.valid = 1'b1;
            ni.err   = model_err(iaddr);
            ni.data  = ni.err ? 32'h0 : model_mem[model_idx(iaddr)];
            if (!ni.err) model_loads = sat(model_loads + 1);
        end
        if (dcmd == C_LOAD) begin
            nd.valid = 1'b1;
            nd.err   = model_err(daddr);
            nd.data  = nd.err ? 32'h0 : model_mem[model_idx(daddr)];
            if (!nd.err) model_loads = sat(model_loads + 1);
        end else if (dcmd == C_STORE) begin
            nd.valid = 1'b1;
            nd.err   = model_err(daddr);
            if (!nd.err) begin
                model_mem[model_idx(daddr)] = wdata;
                model_stores = sat(model_stores + 1);
            end
        end
        exp_i.push_back(ni);
        exp_d.push_back(nd);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(C_NONE, 32'h0, C_NONE, 32'h0, 32'h0);
    endtask

    // Reset for n cycles from a falling edge; outputs must read 0 while held.
    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.i_cmd = C_NONE; bus.i_addr = 32'h0;
        bus.d_cmd = C_NONE; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            check("rst_i_rvalid", {31'h0, bus.i_rvalid}, 32'h0);
            check("rst_i_rdata",  bus.i_rdata, 32'h0);
            check("rst_d_rvalid", {31'h0, bus.d_rvalid}, 32'h0);
            check("rst_d_rdata",  bus.d_rdata, 32'h0);
            check("rst_err", {30'h0, bus.i_err, bus.d_err}, 32'h0);
            check("rst_counts", load_count | store_count, 32'h0);
        end
        rst = 1'b0;
        refill();
    endtask

    logic [1:0]  r_icmd, r_dcmd;
    logic [31:0] r_iaddr, r_daddr;

    initial begin
        for (int k = 0; k < DEPTH; k++) model_mem[k] = 32'h0;
        rst = 1'b1;
        bus.i_cmd = C_NONE; bus.i_addr = 32'h0;
        bus.d_cmd = C_NONE; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        @(negedge clk);
        do_reset(2);

        // Clear the array so every word has a known value.
        for (int k = 0; k < DEPTH; k++) step(C_NONE, 32'h0, C_STORE, 32'(k * 4), 32'h0);
        idle(LAT);
        do_reset(1);

        // Store then immediately load the same word.
        step(C_NONE, 32'h0, C_STORE, 32'h40, 32'hDEAD_BEEF);
        step(C_NONE, 32'h0, C_LOAD,  32'h40, 32'h0);
        idle(LAT);
        check("tp_store_count", store_count, 32'h1);
        check("tp_load_count",  load_count,  32'h1);

        // Same-cycle I-load and D-store to one word: old data, then new data.
        step(C_LOAD, 32'h80, C_STORE, 32'h80, 32'h1234_5678);
        step(C_LOAD, 32'h80, C_NONE,  32'h0,  32'h0);
        idle(LAT);

        // Back-to-back I-loads return in order without gaps.
        for (int k = 0; k < 4; k++) step(C_NONE, 32'h0, C_STORE, 32'(k * 4), 32'h1000 + 32'(k));
        for (int k = 0; k < 4; k++) step(C_LOAD, 32'(k * 4), C_NONE, 32'h0, 32'h0);
        idle(LAT + 1);

        // Misaligned store and out-of-range load, then read back the affected words.
        step(C_NONE, 32'h0, C_STORE, 32'h42, 32'hBAD0_BAD0);
        step(C_NONE, 32'h0, C_LOAD, 32'(DEPTH * 4), 32'h0);
        step(C_LOAD, 32'h40, C_LOAD, 32'h0, 32'h0);
        idle(LAT);

        // Reset while responses are in flight: they must be dropped.
        step(C_LOAD, 32'h4, C_STORE, 32'h20, 32'hCAFE_F00D);
        step(C_LOAD, 32'h8, C_LOAD, 32'h20, 32'h0);
        do_reset(1);
        idle(LAT + 2);
        step(C_LOAD, 32'h20, C_NONE, 32'h0, 32'h0);
        idle(LAT);

        // Load counter saturation with a double increment.
        force dut.load_count_r = 32'hFFFF_FFFE;
        #1;
        release dut.load_count_r;
        model_loads = 64'h0000_0000_FFFF_FFFE;
        step(C_LOAD, 32'h0, C_LOAD, 32'h4, 32'h0);
        step(C_LOAD, 32'h8, C_LOAD, 32'hC, 32'h0);
        idle(LAT);
        check("tp_load_sat", load_count, 32'hFFFF_FFFF);

        // Random traffic, including reserved codes and bad addresses.
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            r_icmd  = 2'($urandom_range(0, 3));
            r_dcmd  = 2'($urandom_range(0, 3));
            r_iaddr = 32'($urandom_range(0, DEPTH * 8 - 1));
            r_daddr = 32'($urandom_range(0, DEPTH * 8 - 1));
            if ($urandom_range(0, 3) != 0) r_iaddr = r_iaddr & 32'h0000_00FC;
            if ($urandom_range(0, 3) != 0) r_daddr = r_daddr & 32'h0000_00FC;
            step(r_icmd, r_iaddr, r_dcmd, r_daddr, $urandom);
        end
        idle(LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_responder.md
# dual_port_mem_responder

Memory-side responder for the processor's instruction and data buses. It serves instruction fetches on a read-only I-port and loads/stores on a D-port, both backed by one shared word array. Every accepted command gets one response after a fixed, parameterized latency, delivered through a delay line. It is the slave end of the `BUS_LOAD`/`BUS_STORE` protocol that the pipeline drives, and it replaces the ideal zero-latency memory in the system testbench.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- LATENCY, 1: response latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_cmd  in  2  I-port command; BUS_LOAD or BUS_NONE, any other code treated as BUS_NONE
- i_addr  in  32  I-port byte address
- i_rdata  out  32  fetched word; 0 when i_rvalid is low
- i_rvalid  out  1  I-port response valid
- i_err  out  1  I-port response error; qualified by i_rvalid
- d_cmd  in  2  D-port command; BUS_NONE, BUS_LOAD or BUS_STORE
- d_addr  in  32  D-port byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; 0 for store acknowledgements and when d_rvalid is low
- d_rvalid  out  1  D-port response valid, for loads and stores
- d_err  out  1  D-port response error; qualified by d_rvalid
- load_count  out  32  error-free loads accepted, both ports combined
- store_count  out  32  error-free stores accepted

## Operation
- Encodings: BUS_NONE=2'b00, BUS_LOAD=2'b01, BUS_STORE=2'b10; 2'b11 is reserved and treated as BUS_NONE.
- No backpressure. A new command can be accepted on each port every cycle, and the ports operate independently.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Load: the array is read at the sampling edge, and the word enters the port's delay line.
- Store: the array word is written at the sampling edge, and an acknowledgement enters the D delay line.
- Read/write ordering:
  - Same cycle, I-load and D-store to the same word: the I-port returns the old data (read-before-write).
  - D-store in cycle t followed by a load of that word in cycle t+1 on either port: the load returns the new data.
- Error checks (only with MEM_ERR_CHECK_EN): an error occurs when addr[1:0] is nonzero or the address is at or above DEPTH_WORDS*4.
  - An errored store does not write the array.
  - An errored response has rdata=0 and err=1.
  - Errored commands are not counted.
- Counters:
  - load_count increments by 0, 1 or 2 per cycle, since both ports can load in the same cycle.
  - store_count increments by 0 or 1.
  - Both saturate at 32'hFFFF_FFFF.
- The array is not reset. In simulation it is initialized to 0.

## Timing
- A command presented in cycle t produces its response in cycle t+LATENCY. rvalid is high for exactly one cycle per command.
- Back-to-back commands produce back-to-back responses, in order, with no gaps.
- Reset values: i_rdata=0, i_rvalid=0, i_err=0, d_rdata=0, d_rvalid=0, d_err=0, load_count=0, store_count=0.
- Reset mid-operation: all in-flight responses are dropped. A store already sampled before reset asserts stays written. Commands are ignored while rst is high.
- A command presented in the first cycle after rst deasserts is accepted normally.

## Configuration
- MEM_ERR_CHECK_EN defined:
  - Misaligned and out-of-range addresses are detected, produce err=1 and are not counted.
  - An errored store is suppressed.
- MEM_ERR_CHECK_EN undefined:
  - addr[1:0] is ignored and the word index wraps modulo DEPTH_WORDS.
  - i_err and d_err are tied to 0.
  - Every non-NONE command is counted.

## Structure
- Package mem_bus_pkg holds:
  - the bus_cmd_t enum (BUS_NONE, BUS_LOAD, BUS_STORE);
  - the resp_t struct {valid, err, data[31:0]};
  - the function computing the word index.
- Sub-module mem_resp_pipe: a LATENCY-deep resp_t delay line with async reset of the valid bits. It is instantiated once per port.
- The top level holds the array, the error checks and the saturating counters.

## Test plan
- LATENCY=1, D-store 0xDEADBEEF to 0x40 in cycle 0, D-load 0x40 in cycle 1 -> d_rvalid=1 with d_rdata=0 in cycle 1 (ack), then d_rdata=0xDEADBEEF in cycle 2; store_count=1, load_count=1.
- Same cycle, I-load 0x80 and D-store 0x12345678 to 0x80, with the word previously 0x0 -> i_rdata=0x0, and a later load returns 0x12345678.
- LATENCY=3, four consecutive I-loads of 0x0, 0x4, 0x8, 0xC -> i_rvalid high in cycles 3-6, with data in address order.
- MEM_ERR_CHECK_EN defined, D-store to 0x42 and D-load to DEPTH_WORDS*4 -> both responses have d_err=1, the array is unchanged and the counters are unchanged.
- Assert rst for 1 cycle while a LATENCY=4 response is in flight -> no rvalid pulse follows, and all outputs read 0 until a new command's response.
- Force load_count to 32'hFFFF_FFFE, then issue simultaneous I- and D-loads -> load_count=32'hFFFF_FFFF and holds there.
